// File: rtl/irrigation_pkg.sv
// rtl/irrigation_pkg.sv - shared types and constants for the multi-zone irrigation controller
// Purpose: FSM state encoding, tank level codes, run-mode constants and the
//          tank sensor decoder used by multizone_irrigation_ctrl.
// Ports:   none (package)
package irrigation_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SELECT   = 3'd1,
      ST_RUN      = 3'd2,
      ST_COOLDOWN = 3'd3,
      ST_FAULT    = 3'd4
   } state_t;

   localparam logic [1:0] LVL_EMPTY  = 2'd0;
   localparam logic [1:0] LVL_LOW    = 2'd1;
   localparam logic [1:0] LVL_MIDDLE = 2'd2;
   localparam logic [1:0] LVL_HIGH   = 2'd3;

   localparam logic MODE_SPRINKLER = 1'b1;
   localparam logic MODE_DRIP      = 1'b0;

   // Returns {valid, level}. Sensors fill bottom-up, so only the four
   // thermometer codes are physically possible; anything else is a fault.
   function automatic logic [2:0] tank_decode(input logic h, input logic m, input logic l);
      case ({h, m, l})
         3'b000:  return {1'b1, LVL_EMPTY};
         3'b001:  return {1'b1, LVL_LOW};
         3'b011:  return {1'b1, LVL_MIDDLE};
         3'b111:  return {1'b1, LVL_HIGH};
         default: return {1'b0, LVL_EMPTY};
      endcase
   endfunction

endpackage

// File: rtl/zone_rr_arbiter.sv
// rtl/zone_rr_arbiter.sv - combinational round-robin zone arbiter
// Purpose: picks the first requesting zone strictly after ptr, wrapping, so the
//          zone at ptr itself has lowest priority.
// Ports:   req   in  N_ZONES  per-zone request (soil dry)
//          ptr   in  clog2    index of the previously granted zone
//          grant out N_ZONES  one-hot grant
//          idx   out 3        index of the granted zone
//          any   out 1        a grant was made
module zone_rr_arbiter
   import irrigation_pkg::*;
#(
   parameter int N_ZONES = 4
) (
   input  logic [N_ZONES-1:0]         req,
   input  logic [$clog2(N_ZONES)-1:0] ptr,
   output logic [N_ZONES-1:0]         grant,
   output logic [2:0]                 idx,
   output logic                       any
);

   localparam int PW = $clog2(N_ZONES);

   logic [PW-1:0] j;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = '0;
      for (int i = 1; i <= N_ZONES; i++) begin
         j = PW'((int'(ptr) + i) % N_ZONES);
         if (!any && req[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            idx      = 3'(j);
         end
      end
   end

endmodule

// File: rtl/multizone_irrigation_ctrl.sv
// rtl/multizone_irrigation_ctrl.sv - one-pump, N-zone round-robin irrigation controller
// Purpose: supervises the tank (level, error, alarm, refill valve) and runs one
//          zone at a time for a timed sprinkler or drip cycle, with a pump
//          cooldown after every run and a timed hold after any alarm.
// Ports:   clk, reset (sync, active-high), tick_i timebase pulse,
//          high/middle/low_level_i tank sensors, soil_dry_i per zone,
//          temperature_i, air_humidity_i, enable_i;
//          error_o, alarm_o, inlet_valve_o, zone_valve_o (one-hot),
//          sprinkler_o, drip_o, active_zone_o, remaining_o, tank_level_o.
module multizone_irrigation_ctrl
   import irrigation_pkg::*;
#(
   parameter int N_ZONES         = 4,
   parameter int TICK_W          = 8,
   parameter int SPRINKLER_TICKS = 30,
   parameter int DRIP_TICKS      = 60,
   parameter int COOLDOWN_TICKS  = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick_i,
   input  logic               high_level_i,
   input  logic               middle_level_i,
   input  logic               low_level_i,
   input  logic [N_ZONES-1:0] soil_dry_i,
   input  logic               temperature_i,
   input  logic               air_humidity_i,
   input  logic               enable_i,
   output logic               error_o,
   output logic               alarm_o,
   output logic               inlet_valve_o,
   output logic [N_ZONES-1:0] zone_valve_o,
   output logic               sprinkler_o,
   output logic               drip_o,
   output logic [2:0]         active_zone_o,
   output logic [TICK_W-1:0]  remaining_o,
   output logic [1:0]         tank_level_o
);

   localparam int PW = $clog2(N_ZONES);
   localparam logic [TICK_W-1:0] SPR_T  = TICK_W'(SPRINKLER_TICKS);
   localparam logic [TICK_W-1:0] DRIP_T = TICK_W'(DRIP_TICKS);
   localparam logic [TICK_W-1:0] CD_T   = TICK_W'(COOLDOWN_TICKS);

   state_t        state;
   logic [PW-1:0] rr_ptr;

   logic          dec_valid;
   logic [1:0]    dec_level;
   logic [1:0]    lvl_c;
   logic          alarm_c;
   logic          sel_mode;

   logic [N_ZONES-1:0] arb_grant;
   logic [2:0]         arb_idx;
   logic               arb_any;

   // On an invalid code the FSM keeps working from the last valid level.
   always_comb begin
      {dec_valid, dec_level} = tank_decode(high_level_i, middle_level_i, low_level_i);
      lvl_c    = dec_valid ? dec_level : tank_level_o;
      alarm_c  = ~dec_valid | (lvl_c == LVL_EMPTY);
      sel_mode = (temperature_i & ~air_humidity_i & (lvl_c >= LVL_MIDDLE)) ? MODE_SPRINKLER
                                                                           : MODE_DRIP;
   end

   zone_rr_arbiter #(.N_ZONES(N_ZONES)) u_arb (
      .req   (soil_dry_i),
      .ptr   (rr_ptr),
      .grant (arb_grant),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         rr_ptr        <= PW'(N_ZONES - 1);
         error_o       <= 1'b0;
         alarm_o       <= 1'b0;
         inlet_valve_o <= 1'b0;
         zone_valve_o  <= '0;
         sprinkler_o   <= 1'b0;
         drip_o        <= 1'b0;
         active_zone_o <= '0;
         remaining_o   <= '0;
         tank_level_o  <= LVL_EMPTY;
      end else begin
         error_o <= ~dec_valid;
         alarm_o <= alarm_c;
         if (dec_valid)
            tank_level_o <= dec_level;

         // Refill hysteresis: open below middle, close only when full.
         if (!dec_valid)
            inlet_valve_o <= 1'b0;
         else if (dec_level < LVL_MIDDLE)
            inlet_valve_o <= 1'b1;
         else if (dec_level == LVL_HIGH)
            inlet_valve_o <= 1'b0;

         case (state)
            ST_IDLE: begin
               zone_valve_o  <= '0;
               sprinkler_o   <= 1'b0;
               drip_o        <= 1'b0;
               active_zone_o <= '0;
               if (alarm_c) begin
                  state       <= ST_FAULT;
                  remaining_o <= CD_T;
               end else if (enable_i && |soil_dry_i) begin
                  state <= ST_SELECT;
               end
            end

            ST_SELECT: begin
               if (arb_any) begin
                  state         <= ST_RUN;
                  rr_ptr        <= arb_idx[PW-1:0];
                  zone_valve_o  <= arb_grant;
                  active_zone_o <= arb_idx;
                  sprinkler_o   <= (sel_mode == MODE_SPRINKLER);
                  drip_o        <= (sel_mode == MODE_DRIP);
                  remaining_o   <= (sel_mode == MODE_SPRINKLER) ? SPR_T : DRIP_T;
               end else begin
                  state <= ST_IDLE;
               end
            end

            // rr_ptr equals the granted zone for the whole run.
            ST_RUN: begin
               if (alarm_c) begin
                  state         <= ST_FAULT;
                  zone_valve_o  <= '0;
                  sprinkler_o   <= 1'b0;
                  drip_o        <= 1'b0;
                  active_zone_o <= '0;
                  remaining_o   <= CD_T;
               end else if (remaining_o == '0 || !soil_dry_i[rr_ptr] ||
                            (sprinkler_o && lvl_c < LVL_MIDDLE)) begin
                  state        <= ST_COOLDOWN;
                  zone_valve_o <= '0;
                  sprinkler_o  <= 1'b0;
                  drip_o       <= 1'b0;
                  remaining_o  <= CD_T;
               end else if (tick_i) begin
                  remaining_o <= remaining_o - TICK_W'(1);
               end
            end

            ST_COOLDOWN: begin
               if (alarm_c) begin
                  state         <= ST_FAULT;
                  active_zone_o <= '0;
                  remaining_o   <= CD_T;
               end else if (remaining_o == '0) begin
                  state         <= ST_IDLE;
                  active_zone_o <= '0;
               end else if (tick_i) begin
                  remaining_o <= remaining_o - TICK_W'(1);
               end
            end

            ST_FAULT: begin
               zone_valve_o  <= '0;
               sprinkler_o   <= 1'b0;
               drip_o        <= 1'b0;
               active_zone_o <= '0;
               if (alarm_c)
                  remaining_o <= CD_T;
               else if (remaining_o == '0)
                  state <= ST_IDLE;
               else if (tick_i)
                  remaining_o <= remaining_o - TICK_W'(1);
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multizone_irrigation_ctrl.sv
// tb/tb_multizone_irrigation_ctrl.sv - directed self-checking bench for multizone_irrigation_ctrl
module tb_multizone_irrigation_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick_i;
   logic       high_level_i, middle_level_i, low_level_i;
   logic [3:0] soil_dry_i;
   logic       temperature_i, air_humidity_i, enable_i;
   logic       error_o, alarm_o, inlet_valve_o, sprinkler_o, drip_o;
   logic [3:0] zone_valve_o;
   logic [2:0] active_zone_o;
   logic [7:0] remaining_o;
   logic [1:0] tank_level_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multizone_irrigation_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .tick_i         (tick_i),
      .high_level_i   (high_level_i),
      .middle_level_i (middle_level_i),
      .low_level_i    (low_level_i),
      .soil_dry_i     (soil_dry_i),
      .temperature_i  (temperature_i),
      .air_humidity_i (air_humidity_i),
      .enable_i       (enable_i),
      .error_o        (error_o),
      .alarm_o        (alarm_o),
      .inlet_valve_o  (inlet_valve_o),
      .zone_valve_o   (zone_valve_o),
      .sprinkler_o    (sprinkler_o),
      .drip_o         (drip_o),
      .active_zone_o  (active_zone_o),
      .remaining_o    (remaining_o),
      .tank_level_o   (tank_level_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick_i = 1'b1;
         @(negedge clk);
         tick_i = 1'b0;
      end
   endtask

   task automatic set_level(input logic h, input logic m, input logic l);
      high_level_i   = h;
      middle_level_i = m;
      low_level_i    = l;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valves"}, {zone_valve_o, sprinkler_o, drip_o, inlet_valve_o}, 32'h0);
      chk({tag, "_flags"},  {error_o, alarm_o, tank_level_o, active_zone_o}, 32'h0);
      chk({tag, "_remain"}, remaining_o, 32'd0);
   endtask

   initial begin
      reset = 1'b1; tick_i = 1'b0;
      set_level(1, 1, 1);
      soil_dry_i = 4'b0101; temperature_i = 1'b0; air_humidity_i = 1'b0; enable_i = 1'b1;
      step(2);
      chk_all_zero("reset");

      // Scenario 1: zone 0 drip, cooldown, then zone 2
      reset = 1'b0;
      step(1);
      chk("s1_tank_lvl", tank_level_o, 32'd3);
      chk("s1_select_no_valve", zone_valve_o, 32'h0);
      step(1);
      chk("s1_run_valve", zone_valve_o, 32'b0001);
      chk("s1_run_mode", {sprinkler_o, drip_o}, 32'b01);
      chk("s1_run_load", remaining_o, 32'd60);
      ticks(59);
      chk("s1_remain_1", remaining_o, 32'd1);
      chk("s1_still_open", zone_valve_o, 32'b0001);
      ticks(1);
      chk("s1_remain_0", remaining_o, 32'd0);
      step(1);
      chk("s1_cd_valve", {zone_valve_o, drip_o}, 32'h0);
      chk("s1_cd_load", remaining_o, 32'd5);
      ticks(5);
      chk("s1_cd_end", remaining_o, 32'd0);
      step(3);
      chk("s1_zone2_valve", zone_valve_o, 32'b0100);
      chk("s1_zone2_idx", active_zone_o, 32'd2);

      // Scenario 4: soil dries up early, pointer moves on
      ticks(10);
      chk("s4_remain_50", remaining_o, 32'd50);
      soil_dry_i = 4'b0001;
      step(1);
      chk("s4_early_cd_valve", zone_valve_o, 32'h0);
      chk("s4_early_cd_load", remaining_o, 32'd5);
      chk("s4_cd_idx", active_zone_o, 32'd2);
      soil_dry_i = 4'b1011;
      ticks(5);
      step(3);
      chk("s4_rr_next_zone", zone_valve_o, 32'b1000);
      chk("s4_rr_idx", active_zone_o, 32'd3);

      // Scenario 2: sprinkler at level 2, middle drops mid-run
      soil_dry_i = 4'b0000;
      temperature_i = 1'b1; air_humidity_i = 1'b0;
      set_level(0, 1, 1);
      step(1);
      chk("s2_cd_valve", zone_valve_o, 32'h0);
      chk("s2_lvl2", tank_level_o, 32'd2);
      chk("s5_inlet_hold_down", inlet_valve_o, 32'd0);
      soil_dry_i = 4'b0001;
      ticks(5);
      step(3);
      chk("s2_wrap_valve", zone_valve_o, 32'b0001);
      chk("s2_mode", {sprinkler_o, drip_o}, 32'b10);
      chk("s2_load", remaining_o, 32'd30);
      ticks(3);
      chk("s2_remain_27", remaining_o, 32'd27);
      middle_level_i = 1'b0;
      step(1);
      chk("s2_close", {zone_valve_o, sprinkler_o}, 32'h0);
      chk("s2_cd_load", remaining_o, 32'd5);
      chk("s2_lvl1", tank_level_o, 32'd1);
      chk("s5_inlet_on", inlet_valve_o, 32'd1);

      // Scenario 5: inlet hysteresis on the way back up
      middle_level_i = 1'b1;
      step(1);
      chk("s5_lvl2", tank_level_o, 32'd2);
      chk("s5_inlet_hold_up", inlet_valve_o, 32'd1);
      high_level_i = 1'b1;
      step(1);
      chk("s5_inlet_off", inlet_valve_o, 32'd0);
      soil_dry_i = 4'b0000; temperature_i = 1'b0;
      ticks(5);
      step(1);
      chk("s5_idle_idx", active_zone_o, 32'd0);
      chk("s5_idle_remain", remaining_o, 32'd0);

      // Scenario 3: invalid sensor code during RUN; enable low does not abort
      soil_dry_i = 4'b0010;
      step(2);
      chk("s3_run_valve", zone_valve_o, 32'b0010);
      chk("s3_run_idx", active_zone_o, 32'd1);
      enable_i = 1'b0;
      ticks(3);
      chk("s3_enable_low_keeps_run", {zone_valve_o, remaining_o}, {4'b0010, 8'd57});
      enable_i = 1'b1;
      set_level(1, 0, 1);
      step(1);
      chk("s3_err_alarm", {error_o, alarm_o}, 32'b11);
      chk("s3_valves_off", {zone_valve_o, sprinkler_o, drip_o, inlet_valve_o}, 32'h0);
      chk("s3_lvl_held", tank_level_o, 32'd3);
      chk("s3_idx_zero", active_zone_o, 32'd0);
      ticks(1);
      chk("s3_hold_reload", remaining_o, 32'd5);
      set_level(1, 1, 1);
      step(1);
      chk("s3_err_clear", {error_o, alarm_o}, 32'b00);
      ticks(5);
      chk("s3_hold_done", {zone_valve_o, remaining_o}, 32'h0);
      step(1);
      chk("s3_idle", {zone_valve_o, active_zone_o}, 32'h0);
      step(2);
      chk("s3_rerun", zone_valve_o, 32'b0010);

      // Scenario 6: reset mid-run, zone 0 wins afterwards
      reset = 1'b1;
      step(1);
      chk_all_zero("s6_reset");
      reset = 1'b0;
      soil_dry_i = 4'b1111;
      step(2);
      chk("s6_zone0_first", zone_valve_o, 32'b0001);
      chk("s6_load", remaining_o, 32'd60);

      // Empty tank during RUN raises alarm without error
      set_level(0, 0, 0);
      step(1);
      chk("empty_alarm", {error_o, alarm_o, tank_level_o}, 32'b0100);
      chk("empty_inlet_valve", {inlet_valve_o, zone_valve_o}, 32'b10000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
